fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter BUF_BYTES, default 32, ring capacity in bytes (power of two).
REQ-002 SHALL have parameter FETCH_BYTES, default 8, bytes per fetch beat.
REQ-003 SHALL have parameter WIN_BYTES, default 15, decode window width in bytes.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have fetch_valid  in  1  fetch_data holds FETCH_BYTES new bytes.
REQ-007 SHALL have fetch_data  in  64  fetched bytes; memory byte k at bits [8k+7:8k].
REQ-008 SHALL have fetch_ready  out  1  ring can accept one full beat this cycle.
REQ-009 SHALL have flush  in  1  discard all buffered bytes (redirect).
REQ-010 SHALL have flush_addr  in  64  new window address on flush.
REQ-011 SHALL have window  out  [0:119]  oldest byte at bits [0:7], next at [8:15], etc.
REQ-012 SHALL have win_valid  out  1  at least WIN_BYTES bytes buffered.
REQ-013 SHALL have win_count  out  6  number of buffered bytes (0..BUF_BYTES).
REQ-014 SHALL have win_addr  out  64  address of window byte 0.
REQ-015 SHALL have consume_valid  in  1  decoder retires consume_len bytes.
REQ-016 SHALL have consume_len  in  4  byte count retired (the decoder's byte increment), legal 1..15.
REQ-017 SHALL have consume_err  out  1  sticky illegal-consume flag.

Function
REQ-018 SHALL keep head, tail (log2(BUF_BYTES) bits, wrap modulo BUF_BYTES) and count registers.
REQ-019 SHALL drive fetch_ready = (count <= BUF_BYTES-FETCH_BYTES), from registered count only; no combinational path from consume inputs.
REQ-020 SHALL, on fetch_valid && fetch_ready, write the 8 bytes at tail..tail+7 (wrapping) and advance tail by 8.
REQ-021 SHALL ignore fetch_valid when fetch_ready is 0 (no write, no pointer change).
REQ-022 SHALL treat consume as legal iff consume_valid && 1 <= consume_len <= count and consume_len <= WIN_BYTES.
REQ-023 SHALL, on legal consume, advance head and win_addr by consume_len.
REQ-024 SHALL, on illegal consume, leave head/count/win_addr unchanged and set consume_err.
REQ-025 SHALL apply simultaneous accepted fetch and legal consume in the same edge: count_next = count + 8 - consume_len.
REQ-026 SHALL make newly written bytes visible on window one cycle after the accepting edge.
REQ-027 SHALL drive window byte i = ring[(head+i) mod BUF_BYTES] combinationally from registers; bytes at i >= count are don't-care.
REQ-028 SHALL drive win_valid = (count >= WIN_BYTES).
REQ-029 SHALL give flush priority: head, tail, count <= 0, win_addr <= flush_addr; same-cycle fetch and consume discarded; consume_err unchanged.
REQ-030 SHALL, with fetch in the cycle after flush, accept bytes at the new address normally.

Reset
REQ-031 SHALL, while reset_n = 0, hold head, tail, count, win_addr, consume_err at 0; fetch_ready = 1, win_valid = 0, win_count = 0.
REQ-032 SHALL, on reset assertion mid-operation, drop all buffered bytes immediately; ring contents need not be cleared.
REQ-033 SHALL clear consume_err only by reset.

Structure
REQ-034 SHALL place BUF_BYTES, FETCH_BYTES, WIN_BYTES defaults and the window type in shared package decoder_pkg.
REQ-035 SHALL isolate byte storage, write port and window read mux in one sub-module fetch_byte_ring; pointer/count/address control stays in fetch_buffer.

Verification
REQ-036 Reset, then 2 beats 0x0706050403020100, 0x0F0E0D0C0B0A0908 -> win_count 16, win_valid 1, window bytes 00..0E in order.
REQ-037 4 beats back-to-back -> count 32, fetch_ready 0; 5th beat ignored; consume 9 -> count 23, fetch_ready 1.
REQ-038 count 16, fetch beat + consume_len 3 same edge -> count 21, win_addr +3, window byte 0 = old byte 3.
REQ-039 Fill/consume until tail wraps past byte 31 -> window contiguous across wrap (e.g. head 28 shows bytes 28..31,0..10).
REQ-040 count 4, consume_len 5 -> state unchanged, consume_err 1 and stays 1; consume_len 0 -> same.
REQ-041 flush with flush_addr 0x400000 plus fetch and consume same cycle -> count 0, win_addr 0x400000, win_valid 0; reset_n low mid-fill -> outputs at reset values immediately.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the instruction fetch/decode front end.
// Holds the default ring geometry, the fixed interface widths and the
// decode window type used by fetch_buffer and its interface.
package decoder_pkg;

  localparam int DEF_BUF_BYTES   = 32;
  localparam int DEF_FETCH_BYTES = 8;
  localparam int DEF_WIN_BYTES   = 15;

  localparam int ADDR_W = 64;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = $clog2(DEF_BUF_BYTES) + 1;

  // Byte 0 (oldest) sits at bits [0:7], byte 1 at [8:15], and so on.
  typedef logic [0:8*DEF_WIN_BYTES-1]  window_t;
  typedef logic [8*DEF_FETCH_BYTES-1:0] beat_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundle of the fetch, redirect, decode-window and consume signals of
// fetch_buffer.
//   master : fetch unit / decoder side (drives beats, flush, consume)
//   slave  : fetch_buffer (drives fetch_ready, window, status, error)
interface fetch_buffer_if;
  import decoder_pkg::*;

  logic                fetch_valid;
  beat_t               fetch_data;
  logic                fetch_ready;
  logic                flush;
  logic [ADDR_W-1:0]   flush_addr;
  window_t             window;
  logic                win_valid;
  logic [CNT_W-1:0]    win_count;
  logic [ADDR_W-1:0]   win_addr;
  logic                consume_valid;
  logic [LEN_W-1:0]    consume_len;
  logic                consume_err;

  modport master (
    output fetch_valid, fetch_data, flush, flush_addr, consume_valid, consume_len,
    input  fetch_ready, window, win_valid, win_count, win_addr, consume_err
  );

  modport slave (
    input  fetch_valid, fetch_data, flush, flush_addr, consume_valid, consume_len,
    output fetch_ready, window, win_valid, win_count, win_addr, consume_err
  );

endinterface

// File: rtl/fetch_byte_ring.sv
// Byte storage of the fetch ring.
//   clk     : rising-edge clock
//   wr_en   : write one beat this edge
//   wr_ptr  : ring index of the first byte of the beat
//   wr_data : beat, byte k at bits [8k+7:8k]
//   rd_ptr  : ring index of window byte 0
//   window  : WIN_BYTES consecutive ring bytes starting at rd_ptr (wrapping)
// Storage holds no reset: validity is tracked by the count in the parent.
module fetch_byte_ring
  import decoder_pkg::*;
#(
  parameter int BUF_BYTES   = DEF_BUF_BYTES,
  parameter int FETCH_BYTES = DEF_FETCH_BYTES,
  parameter int WIN_BYTES   = DEF_WIN_BYTES
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(BUF_BYTES)-1:0] wr_ptr,
  input  logic [8*FETCH_BYTES-1:0]     wr_data,
  input  logic [$clog2(BUF_BYTES)-1:0] rd_ptr,
  output logic [0:8*WIN_BYTES-1]       window
);

  localparam int PTR_W = $clog2(BUF_BYTES);

  logic [7:0] mem [BUF_BYTES];

  // Index arithmetic is PTR_W wide, so the beat wraps around the ring end.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < FETCH_BYTES; k++) begin
        mem[wr_ptr + PTR_W'(k)] <= wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      window[8*i +: 8] = mem[rd_ptr + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch ring buffer feeding a variable-length decoder.
// Fetch beats of FETCH_BYTES bytes are appended at tail; the decoder sees
// the oldest WIN_BYTES bytes as a window and retires 1..WIN_BYTES bytes per
// consume. A flush redirects the stream to a new address.
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fetch_buffer_if.slave (fetch beat in, flush, window out,
//             consume in, sticky consume_err)
module fetch_buffer
  import decoder_pkg::*;
#(
  parameter int BUF_BYTES   = DEF_BUF_BYTES,
  parameter int FETCH_BYTES = DEF_FETCH_BYTES,
  parameter int WIN_BYTES   = DEF_WIN_BYTES
) (
  input  logic           clk,
  input  logic           reset_n,
  fetch_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CW    = PTR_W + 1;

  localparam logic [CW-1:0]    READY_MAX = CW'(BUF_BYTES - FETCH_BYTES);
  localparam logic [CW-1:0]    WIN_MIN   = CW'(WIN_BYTES);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(WIN_BYTES);

  logic [PTR_W-1:0]  head, head_n;
  logic [PTR_W-1:0]  tail, tail_n;
  logic [CW-1:0]     count, count_n;
  logic [ADDR_W-1:0] win_addr_q, win_addr_n;
  logic              err_q, err_n;

  logic fetch_ready_w;
  logic fetch_acc;
  logic consume_ok;

  // Ready depends on the registered count only, so a same-cycle consume
  // never feeds back into the fetch handshake.
  assign fetch_ready_w = (count <= READY_MAX);
  assign fetch_acc     = bus.fetch_valid && fetch_ready_w;

  assign consume_ok = bus.consume_valid
                   && (bus.consume_len != '0)
                   && (CW'(bus.consume_len) <= count)
                   && (bus.consume_len <= LEN_MAX);

  always_comb begin
    head_n     = head;
    tail_n     = tail;
    count_n    = count;
    win_addr_n = win_addr_q;
    err_n      = err_q;
    if (bus.flush) begin
      // Redirect wins over everything; error flag is left as is.
      head_n     = '0;
      tail_n     = '0;
      count_n    = '0;
      win_addr_n = bus.flush_addr;
    end else begin
      if (fetch_acc) begin
        tail_n  = tail + PTR_W'(FETCH_BYTES);
        count_n = count + CW'(FETCH_BYTES);
      end
      if (consume_ok) begin
        head_n     = head + PTR_W'(bus.consume_len);
        count_n    = count_n - CW'(bus.consume_len);
        win_addr_n = win_addr_q + ADDR_W'(bus.consume_len);
      end else if (bus.consume_valid) begin
        err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      win_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      head       <= head_n;
      tail       <= tail_n;
      count      <= count_n;
      win_addr_q <= win_addr_n;
      err_q      <= err_n;
    end
  end

  fetch_byte_ring #(
    .BUF_BYTES   (BUF_BYTES),
    .FETCH_BYTES (FETCH_BYTES),
    .WIN_BYTES   (WIN_BYTES)
  ) u_ring (
    .clk     (clk),
    .wr_en   (fetch_acc && !bus.flush),
    .wr_ptr  (tail),
    .wr_data (bus.fetch_data),
    .rd_ptr  (head),
    .window  (bus.window)
  );

  assign bus.fetch_ready = fetch_ready_w;
  assign bus.win_valid   = (count >= WIN_MIN);
  assign bus.win_count   = CNT_W'(count);
  assign bus.win_addr    = win_addr_q;
  assign bus.consume_err = err_q;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  fetch_buffer_if bus ();

  fetch_buffer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: buffered bytes in stream order, window address, error.
  logic [7:0]  q[$];
  logic [63:0] maddr = 64'h0;
  logic        merr  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [63:0] fd, input logic cv,
                       input logic [3:0] cl, input logic fl, input logic [63:0] fa);
    bus.fetch_valid   = fv;
    bus.fetch_data    = fd;
    bus.consume_valid = cv;
    bus.consume_len   = cl;
    bus.flush         = fl;
    bus.flush_addr    = fa;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 1'b0, 4'd0, 1'b0, 64'h0);
  endtask

  // Applies the behavioural rules to the inputs present at the coming edge.
  task automatic model_step();
    int cnt;
    int len;
    bit legal;
    if (!reset_n) begin
      q.delete();
      maddr = 64'h0;
      merr  = 1'b0;
    end else if (bus.flush) begin
      q.delete();
      maddr = bus.flush_addr;
    end else begin
      cnt   = q.size();
      len   = int'(bus.consume_len);
      legal = bus.consume_valid && len >= 1 && len <= cnt && len <= 15;
      if (bus.consume_valid && !legal) merr = 1'b1;
      if (legal) begin
        for (int k = 0; k < len; k++) void'(q.pop_front());
        maddr = maddr + 64'(len);
      end
      if (bus.fetch_valid && cnt <= 24) begin
        for (int k = 0; k < 8; k++) q.push_back(bus.fetch_data[8*k +: 8]);
      end
    end
  endtask

  task automatic check_all();
    check("win_count",   64'(bus.win_count),   64'(q.size()));
    check("fetch_ready", 64'(bus.fetch_ready), 64'(q.size() <= 24));
    check("win_valid",   64'(bus.win_valid),   64'(q.size() >= 15));
    check("win_addr",    bus.win_addr,         maddr);
    check("consume_err", 64'(bus.consume_err), 64'(merr));
    for (int i = 0; i < 15 && i < q.size(); i++) begin
      check($sformatf("window[%0d]", i), 64'(bus.window[8*i +: 8]), 64'(q[i]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Beat whose bytes equal their stream position base..base+7.
  function automatic logic [63:0] beat_at(input int base);
    logic [63:0] b;
    for (int k = 0; k < 8; k++) b[8*k +: 8] = 8'(base + k);
    return b;
  endfunction

  initial begin
    reset_n = 1'b0;
    idle();

    // Reset state
    cycle();
    cycle();
    check("rst win_count", 64'(bus.win_count), 64'd0);
    check("rst fetch_ready", 64'(bus.fetch_ready), 64'd1);
    check("rst win_valid", 64'(bus.win_valid), 64'd0);
    reset_n = 1'b1;

    // Two beats, window shows bytes 00..0E
    drive(1'b1, 64'h0706050403020100, 1'b0, 4'd0, 1'b0, 64'h0); cycle();
    drive(1'b1, 64'h0F0E0D0C0B0A0908, 1'b0, 4'd0, 1'b0, 64'h0); cycle();
    idle();
    check("two beats count", 64'(bus.win_count), 64'd16);
    check("two beats win_valid", 64'(bus.win_valid), 64'd1);
    for (int i = 0; i < 15; i++) check($sformatf("two beats byte%0d", i), 64'(bus.window[8*i +: 8]), 64'(i));

    // Fill to capacity, overflow beat ignored, consume 9
    drive(1'b1, beat_at(16), 1'b0, 4'd0, 1'b0, 64'h0); cycle();
    drive(1'b1, beat_at(24), 1'b0, 4'd0, 1'b0, 64'h0); cycle();
    check("full count", 64'(bus.win_count), 64'd32);
    check("full ready", 64'(bus.fetch_ready), 64'd0);
    drive(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 4'd0, 1'b0, 64'h0); cycle();
    check("ignored beat count", 64'(bus.win_count), 64'd32);
    drive(1'b0, 64'h0, 1'b1, 4'd9, 1'b0, 64'h0); cycle();
    check("consume9 count", 64'(bus.win_count), 64'd23);
    check("consume9 ready", 64'(bus.fetch_ready), 64'd1);

    // Down to 16, then fetch + consume 3 on the same edge
    drive(1'b0, 64'h0, 1'b1, 4'd7, 1'b0, 64'h0); cycle();
    check("count16", 64'(bus.win_count), 64'd16);
    drive(1'b1, beat_at(32), 1'b1, 4'd3, 1'b0, 64'h0); cycle();
    check("simul count", 64'(bus.win_count), 64'd21);
    check("simul addr", bus.win_addr, 64'd19);
    check("simul byte0", 64'(bus.window[0 +: 8]), 64'h13);

    // Head at 28: window wraps past ring byte 31
    drive(1'b1, beat_at(40), 1'b1, 4'd9, 1'b0, 64'h0); cycle();
    idle();
    check("wrap addr", bus.win_addr, 64'd28);
    for (int i = 0; i < 15; i++) check($sformatf("wrap byte%0d", i), 64'(bus.window[8*i +: 8]), 64'(28 + i));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 10) < 6, {$urandom, $urandom},
            ($urandom % 10) < 6,
            (($urandom % 16) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            ($urandom % 40) == 0, {$urandom, $urandom});
      cycle();
    end
    idle();

    // Reset through an edge, then illegal consumes
    reset_n = 1'b0; cycle();
    reset_n = 1'b1;
    check("rerst err", 64'(bus.consume_err), 64'd0);
    drive(1'b1, beat_at(0), 1'b0, 4'd0, 1'b0, 64'h0); cycle();
    drive(1'b0, 64'h0, 1'b1, 4'd4, 1'b0, 64'h0); cycle();
    check("count4", 64'(bus.win_count), 64'd4);
    drive(1'b0, 64'h0, 1'b1, 4'd5, 1'b0, 64'h0); cycle();
    check("over consume count", 64'(bus.win_count), 64'd4);
    check("over consume addr", bus.win_addr, 64'd4);
    check("over consume err", 64'(bus.consume_err), 64'd1);
    idle(); cycle();
    check("err sticky", 64'(bus.consume_err), 64'd1);
    drive(1'b0, 64'h0, 1'b1, 4'd0, 1'b0, 64'h0); cycle();
    check("zero consume count", 64'(bus.win_count), 64'd4);
    check("zero consume err", 64'(bus.consume_err), 64'd1);

    // Flush with simultaneous fetch and consume, then refill
    drive(1'b1, beat_at(8), 1'b0, 4'd0, 1'b0, 64'h0); cycle();
    drive(1'b1, beat_at(16), 1'b1, 4'd3, 1'b1, 64'h400000); cycle();
    check("flush count", 64'(bus.win_count), 64'd0);
    check("flush addr", bus.win_addr, 64'h400000);
    check("flush win_valid", 64'(bus.win_valid), 64'd0);
    check("flush err kept", 64'(bus.consume_err), 64'd1);
    drive(1'b1, 64'h8877665544332211, 1'b0, 4'd0, 1'b0, 64'h0); cycle();
    idle();
    check("post flush count", 64'(bus.win_count), 64'd8);
    check("post flush byte0", 64'(bus.window[0 +: 8]), 64'h11);

    // Asynchronous reset mid-fill, observed before any clock edge
    drive(1'b1, beat_at(64), 1'b0, 4'd0, 1'b0, 64'h0); cycle();
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    q.delete(); maddr = 64'h0; merr = 1'b0;
    check_all();
    check("async rst count", 64'(bus.win_count), 64'd0);
    check("async rst ready", 64'(bus.fetch_ready), 64'd1);
    check("async rst err", 64'(bus.consume_err), 64'd0);
    cycle();
    reset_n = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
